// File: rtl/adder_result_checker_if.sv
// Interface bundling the stimulus-side operands, the DUT response and the
// checker results for adder_result_checker.
interface adder_result_checker_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
);
   // Control and operands applied to the adder under test
   logic             clear;
   logic             in_valid;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;

   // Response of the adder under test
   logic [WIDTH-1:0] dut_sum;
   logic             dut_cout;

   // Checker results
   logic             chk_valid;
   logic             chk_ok;
   logic [CNT_W-1:0] pass_cnt;
   logic [CNT_W-1:0] fail_cnt;
   logic             err_flag;
   logic [WIDTH-1:0] ff_a;
   logic [WIDTH-1:0] ff_b;
   logic             ff_cin;
   logic [WIDTH:0]   ff_exp;
   logic [WIDTH:0]   ff_got;

   // Environment side: drives operands and the DUT response, observes results
   modport master (
      output clear, in_valid, in_a, in_b, in_cin, dut_sum, dut_cout,
      input  chk_valid, chk_ok, pass_cnt, fail_cnt, err_flag,
             ff_a, ff_b, ff_cin, ff_exp, ff_got
   );

   // Checker side
   modport slave (
      input  clear, in_valid, in_a, in_b, in_cin, dut_sum, dut_cout,
      output chk_valid, chk_ok, pass_cnt, fail_cnt, err_flag,
             ff_a, ff_b, ff_cin, ff_exp, ff_got
   );
endinterface

// File: rtl/adder_result_checker.sv
// Response monitor for the prefix-adder family: recomputes the exact sum of
// the applied operands, delays it by the DUT latency, compares it with the
// DUT sum/carry-out, keeps saturating pass/fail counters and freezes the
// first failing comparison for debug.
module adder_result_checker #(
   parameter int WIDTH   = 16,
   parameter int LATENCY = 0,   // DUT pipeline depth, 0..8
   parameter int CNT_W   = 16
) (
   input logic                     clk,
   input logic                     rst,
   adder_result_checker_if.slave   bus
);

   // One delay-line entry: everything needed to judge and log a comparison
   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             cin;
      logic [WIDTH:0]   gold;
   } stage_t;

   typedef enum logic {
      ST_PASSING = 1'b0,
      ST_FAILED  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   stage_t     w_in;
   stage_t     w_cmp;
   logic       w_flush;
   logic [WIDTH:0] w_got;
   logic       w_match;
   logic       w_fire;
   logic       w_fail;
   logic       w_capture;
   state_t     r_state;
   state_t     w_state_next;

   logic             r_chk_valid;
   logic             r_chk_ok;
   logic [CNT_W-1:0] r_pass_cnt;
   logic [CNT_W-1:0] r_fail_cnt;
   logic [WIDTH-1:0] r_ff_a;
   logic [WIDTH-1:0] r_ff_b;
   logic             r_ff_cin;
   logic [WIDTH:0]   r_ff_exp;
   logic [WIDTH:0]   r_ff_got;

   // rst and clear both discard in-flight work; an in_valid alongside them is dropped
   assign w_flush = rst | bus.clear;

   // Golden result at full WIDTH+1 bits so the carry-out never overflows
   always_comb begin
      w_in.valid = bus.in_valid & ~w_flush;
      w_in.a     = bus.in_a;
      w_in.b     = bus.in_b;
      w_in.cin   = bus.in_cin;
      w_in.gold  = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {{WIDTH{1'b0}}, bus.in_cin};
   end

   generate
      if (LATENCY == 0) begin : g_no_pipe
         assign w_cmp = w_in;
      end else begin : g_pipe
         stage_t r_pipe [LATENCY];

         // Delay line aligning the golden result with the DUT output
         always_ff @(posedge clk) begin
            r_pipe[0] <= w_in;
            for (int i = 1; i < LATENCY; i++) begin
               r_pipe[i] <= r_pipe[i-1];
            end
            // NOTE: only the valid bits are reset; the payload is qualified by
            // valid, so clearing it would just cost reset routing.
            if (w_flush) begin
               for (int i = 0; i < LATENCY; i++) begin
                  r_pipe[i].valid <= 1'b0;
               end
            end
         end

         assign w_cmp = r_pipe[LATENCY-1];
      end
   endgenerate

   // Case equality makes X/Z on the DUT response a mismatch in simulation
   assign w_got   = {bus.dut_cout, bus.dut_sum};
   assign w_match = (w_got === w_cmp.gold);
   assign w_fire  = w_cmp.valid & ~w_flush;
   assign w_fail  = w_fire & ~w_match;

   // FSM state register: PASSING until the first mismatch
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (w_flush) r_state <= ST_PASSING;
      else         r_state <= w_state_next;
   end

   // FSM next state and first-failure capture strobe
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      w_state_next = r_state;
      w_capture    = 1'b0;
      case (r_state)
         ST_PASSING: begin
            if (w_fail) begin
               w_state_next = ST_FAILED;
               w_capture    = 1'b1;
            end
         end
         ST_FAILED: w_state_next = ST_FAILED;
         default:   w_state_next = ST_PASSING;
      endcase
   end

   // Registered results: check pulse, saturating counters and first-failure log
   always_ff @(posedge clk) begin
      if (w_flush) begin
         r_chk_valid <= 1'b0;
         r_chk_ok    <= 1'b0;
         r_pass_cnt  <= '0;
         r_fail_cnt  <= '0;
         r_ff_a      <= '0;
         r_ff_b      <= '0;
         r_ff_cin    <= 1'b0;
         r_ff_exp    <= '0;
         r_ff_got    <= '0;
      end else begin
         r_chk_valid <= w_fire;
         r_chk_ok    <= w_fire & w_match;
         if (w_fire && w_match && (r_pass_cnt != CNT_MAX)) r_pass_cnt <= r_pass_cnt + CNT_ONE;
         if (w_fail && (r_fail_cnt != CNT_MAX))            r_fail_cnt <= r_fail_cnt + CNT_ONE;
         if (w_capture) begin
            r_ff_a   <= w_cmp.a;
            r_ff_b   <= w_cmp.b;
            r_ff_cin <= w_cmp.cin;
            r_ff_exp <= w_cmp.gold;
            r_ff_got <= w_got;
         end
      end
   end

   assign bus.chk_valid = r_chk_valid;
   assign bus.chk_ok    = r_chk_ok;
   assign bus.pass_cnt  = r_pass_cnt;
   assign bus.fail_cnt  = r_fail_cnt;
   assign bus.err_flag  = (r_state == ST_FAILED);
   assign bus.ff_a      = r_ff_a;
   assign bus.ff_b      = r_ff_b;
   assign bus.ff_cin    = r_ff_cin;
   assign bus.ff_exp    = r_ff_exp;
   assign bus.ff_got    = r_ff_got;

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker: three instances cover the
// combinational DUT case, a two-stage DUT and narrow saturating counters.
module tb_adder_result_checker;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   adder_result_checker_if #(.WIDTH(16), .CNT_W(16)) bus0 ();
   adder_result_checker_if #(.WIDTH(16), .CNT_W(16)) bus2 ();
   adder_result_checker_if #(.WIDTH(16), .CNT_W(4))  bus4 ();

   adder_result_checker #(.WIDTH(16), .LATENCY(0), .CNT_W(16)) u_chk0 (.clk(clk), .rst(rst), .bus(bus0));
   adder_result_checker #(.WIDTH(16), .LATENCY(2), .CNT_W(16)) u_chk2 (.clk(clk), .rst(rst), .bus(bus2));
   adder_result_checker #(.WIDTH(16), .LATENCY(0), .CNT_W(4))  u_chk4 (.clk(clk), .rst(rst), .bus(bus4));

   // Two-stage correct adder standing in for a pipelined DUT
   logic [16:0] m1;
   logic [16:0] m2;
   always @(posedge clk) begin
      m1 <= {1'b0, bus2.in_a} + {1'b0, bus2.in_b} + {16'h0, bus2.in_cin};
      m2 <= m1;
   end
   assign bus2.dut_sum  = m2[15:0];
   assign bus2.dut_cout = m2[16];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Directed vectors and hand-computed {cout,sum}
   logic [15:0] va [4];
   logic [15:0] vb [4];
   logic        vc [4];
   logic [16:0] vs [4];

   // Watchdog so the run can never hang
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic pulse_clear0();
      bus0.clear = 1'b1;
      @(negedge clk);
      bus0.clear = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (bus0.chk_valid !== 1'b0) begin n_bad++; $display("FAIL reset_chk_valid got %b want 0", bus0.chk_valid); end
      n_cmp++; if (bus0.pass_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_pass_cnt got %0d want 0", bus0.pass_cnt); end
      n_cmp++; if (bus0.fail_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_fail_cnt got %0d want 0", bus0.fail_cnt); end
      n_cmp++; if (bus0.err_flag !== 1'b0) begin n_bad++; $display("FAIL reset_err_flag got %b want 0", bus0.err_flag); end
      n_cmp++; if (bus0.ff_exp !== 17'h0) begin n_bad++; $display("FAIL reset_ff_exp got %h want 0", bus0.ff_exp); end
      n_cmp++; if (bus2.chk_valid !== 1'b0) begin n_bad++; $display("FAIL reset_chk_valid_l2 got %b want 0", bus2.chk_valid); end
      n_cmp++; if (bus4.pass_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_pass_cnt_c4 got %0d want 0", bus4.pass_cnt); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      for (int k = 0; k < 4; k++) begin
         bus0.in_valid = 1'b1;
         bus0.in_a = va[k]; bus0.in_b = vb[k]; bus0.in_cin = vc[k];
         {bus0.dut_cout, bus0.dut_sum} = vs[k];
         @(negedge clk);
         n_cmp++; if (bus0.chk_valid !== 1'b1) begin n_bad++; $display("FAIL basic_chk_valid[%0d] got %b want 1", k, bus0.chk_valid); end
         n_cmp++; if (bus0.chk_ok !== 1'b1) begin n_bad++; $display("FAIL basic_chk_ok[%0d] got %b want 1", k, bus0.chk_ok); end
      end
      bus0.in_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus0.chk_valid !== 1'b0) begin n_bad++; $display("FAIL basic_idle got %b want 0", bus0.chk_valid); end
      n_cmp++; if (bus0.pass_cnt !== 16'd4) begin n_bad++; $display("FAIL basic_pass_cnt got %0d want 4", bus0.pass_cnt); end
      n_cmp++; if (bus0.fail_cnt !== 16'd0) begin n_bad++; $display("FAIL basic_fail_cnt got %0d want 0", bus0.fail_cnt); end
      n_cmp++; if (bus0.err_flag !== 1'b0) begin n_bad++; $display("FAIL basic_err_flag got %b want 0", bus0.err_flag); end
   endtask

   task automatic test_mismatch();
      pulse_clear0();
      n_cmp++; if (bus0.pass_cnt !== 16'd0) begin n_bad++; $display("FAIL clear_pass_cnt got %0d want 0", bus0.pass_cnt); end
      for (int k = 0; k < 4; k++) begin
         bus0.in_valid = 1'b1;
         bus0.in_a = va[k]; bus0.in_b = vb[k]; bus0.in_cin = vc[k];
         {bus0.dut_cout, bus0.dut_sum} = (k == 2) ? 17'd12 : vs[k];
         @(negedge clk);
         n_cmp++; if (bus0.chk_ok !== (k != 2)) begin n_bad++; $display("FAIL mm_chk_ok[%0d] got %b want %b", k, bus0.chk_ok, (k != 2)); end
         if (k == 2) begin
            n_cmp++; if (bus0.err_flag !== 1'b1) begin n_bad++; $display("FAIL mm_err_flag got %b want 1", bus0.err_flag); end
            n_cmp++; if (bus0.ff_a !== 16'd5) begin n_bad++; $display("FAIL mm_ff_a got %0d want 5", bus0.ff_a); end
            n_cmp++; if (bus0.ff_b !== 16'd5) begin n_bad++; $display("FAIL mm_ff_b got %0d want 5", bus0.ff_b); end
            n_cmp++; if (bus0.ff_cin !== 1'b0) begin n_bad++; $display("FAIL mm_ff_cin got %b want 0", bus0.ff_cin); end
            n_cmp++; if (bus0.ff_exp !== 17'd10) begin n_bad++; $display("FAIL mm_ff_exp got %0d want 10", bus0.ff_exp); end
            n_cmp++; if (bus0.ff_got !== 17'd12) begin n_bad++; $display("FAIL mm_ff_got got %0d want 12", bus0.ff_got); end
         end
      end
      n_cmp++; if (bus0.pass_cnt !== 16'd3) begin n_bad++; $display("FAIL mm_pass_cnt got %0d want 3", bus0.pass_cnt); end
      n_cmp++; if (bus0.fail_cnt !== 16'd1) begin n_bad++; $display("FAIL mm_fail_cnt got %0d want 1", bus0.fail_cnt); end
      // A second failure only counts; the first-failure log stays frozen
      bus0.in_a = 16'd1; bus0.in_b = 16'd1; bus0.in_cin = 1'b0;
      {bus0.dut_cout, bus0.dut_sum} = 17'd7;
      @(negedge clk);
      bus0.in_valid = 1'b0;
      n_cmp++; if (bus0.fail_cnt !== 16'd2) begin n_bad++; $display("FAIL freeze_fail_cnt got %0d want 2", bus0.fail_cnt); end
      n_cmp++; if (bus0.ff_a !== 16'd5) begin n_bad++; $display("FAIL freeze_ff_a got %0d want 5", bus0.ff_a); end
      n_cmp++; if (bus0.ff_got !== 17'd12) begin n_bad++; $display("FAIL freeze_ff_got got %0d want 12", bus0.ff_got); end
      n_cmp++; if (bus0.err_flag !== 1'b1) begin n_bad++; $display("FAIL freeze_err_flag got %b want 1", bus0.err_flag); end
   endtask

   task automatic test_overflow();
      pulse_clear0();
      n_cmp++; if (bus0.err_flag !== 1'b0) begin n_bad++; $display("FAIL ovf_clear_err got %b want 0", bus0.err_flag); end
      bus0.in_valid = 1'b1;
      bus0.in_a = 16'hFFFF; bus0.in_b = 16'h0001; bus0.in_cin = 1'b1;
      {bus0.dut_cout, bus0.dut_sum} = 17'h10001;
      @(negedge clk);
      n_cmp++; if (bus0.chk_ok !== 1'b1) begin n_bad++; $display("FAIL ovf_pass got %b want 1", bus0.chk_ok); end
      {bus0.dut_cout, bus0.dut_sum} = 17'h00001;
      @(negedge clk);
      bus0.in_valid = 1'b0;
      n_cmp++; if (bus0.chk_ok !== 1'b0) begin n_bad++; $display("FAIL ovf_fail got %b want 0", bus0.chk_ok); end
      n_cmp++; if (bus0.ff_exp !== 17'h10001) begin n_bad++; $display("FAIL ovf_ff_exp got %h want 10001", bus0.ff_exp); end
      n_cmp++; if (bus0.ff_got !== 17'h00001) begin n_bad++; $display("FAIL ovf_ff_got got %h want 00001", bus0.ff_got); end
      n_cmp++; if (bus0.ff_cin !== 1'b1) begin n_bad++; $display("FAIL ovf_ff_cin got %b want 1", bus0.ff_cin); end
      n_cmp++; if (bus0.ff_a !== 16'hFFFF) begin n_bad++; $display("FAIL ovf_ff_a got %h want ffff", bus0.ff_a); end
   endtask

   task automatic test_latency2();
      logic pv [14];
      logic hv [17];
      logic want;
      pv = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int s = 0; s < 17; s++) begin
         hv[s] = (s < 14) ? pv[s] : 1'b0;
         bus2.in_valid = hv[s];
         bus2.in_a   = 16'($urandom);
         bus2.in_b   = 16'($urandom);
         bus2.in_cin = 1'($urandom);
         @(negedge clk);
         want = (s >= 2) ? hv[s-2] : 1'b0;
         n_cmp++; if (bus2.chk_valid !== want) begin n_bad++; $display("FAIL l2_chk_valid[%0d] got %b want %b", s, bus2.chk_valid, want); end
         if (want) begin
            n_cmp++; if (bus2.chk_ok !== 1'b1) begin n_bad++; $display("FAIL l2_chk_ok[%0d] got %b want 1", s, bus2.chk_ok); end
         end
      end
      n_cmp++; if (bus2.pass_cnt !== 16'd8) begin n_bad++; $display("FAIL l2_pass_cnt got %0d want 8", bus2.pass_cnt); end
      n_cmp++; if (bus2.fail_cnt !== 16'd0) begin n_bad++; $display("FAIL l2_fail_cnt got %0d want 0", bus2.fail_cnt); end
      n_cmp++; if (bus2.err_flag !== 1'b0) begin n_bad++; $display("FAIL l2_err_flag got %b want 0", bus2.err_flag); end
   endtask

   task automatic test_saturate();
      logic [15:0] a;
      logic [15:0] b;
      for (int k = 0; k < 20; k++) begin
         a = 16'(k * 3);
         b = 16'(k * 7);
         bus4.in_valid = 1'b1;
         bus4.in_a = a; bus4.in_b = b; bus4.in_cin = k[0];
         {bus4.dut_cout, bus4.dut_sum} = {1'b0, a} + {1'b0, b} + {16'h0, k[0]};
         @(negedge clk);
         n_cmp++; if (bus4.chk_ok !== 1'b1) begin n_bad++; $display("FAIL sat_chk_ok[%0d] got %b want 1", k, bus4.chk_ok); end
         if (k == 14 || k == 19) begin
            n_cmp++; if (bus4.pass_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_pass_cnt[%0d] got %0d want 15", k, bus4.pass_cnt); end
         end
      end
      bus4.in_a = 16'd3; bus4.in_b = 16'd4; bus4.in_cin = 1'b0;
      {bus4.dut_cout, bus4.dut_sum} = 17'd8;
      @(negedge clk);
      n_cmp++; if (bus4.fail_cnt !== 4'd1) begin n_bad++; $display("FAIL sat_fail_cnt got %0d want 1", bus4.fail_cnt); end
      n_cmp++; if (bus4.err_flag !== 1'b1) begin n_bad++; $display("FAIL sat_err_flag got %b want 1", bus4.err_flag); end
      // clear together with a (wrong) operand: the operand must be dropped
      bus4.clear = 1'b1;
      bus4.in_a = 16'd1; bus4.in_b = 16'd1;
      {bus4.dut_cout, bus4.dut_sum} = 17'd9;
      @(negedge clk);
      bus4.clear = 1'b0;
      bus4.in_valid = 1'b0;
      n_cmp++; if (bus4.pass_cnt !== 4'd0) begin n_bad++; $display("FAIL clr_pass_cnt got %0d want 0", bus4.pass_cnt); end
      n_cmp++; if (bus4.fail_cnt !== 4'd0) begin n_bad++; $display("FAIL clr_fail_cnt got %0d want 0", bus4.fail_cnt); end
      n_cmp++; if (bus4.err_flag !== 1'b0) begin n_bad++; $display("FAIL clr_err_flag got %b want 0", bus4.err_flag); end
      n_cmp++; if (bus4.chk_valid !== 1'b0) begin n_bad++; $display("FAIL clr_chk_valid got %b want 0", bus4.chk_valid); end
      n_cmp++; if (bus4.ff_a !== 16'd0) begin n_bad++; $display("FAIL clr_ff_a got %0d want 0", bus4.ff_a); end
      @(negedge clk);
      n_cmp++; if (bus4.chk_valid !== 1'b0) begin n_bad++; $display("FAIL clr_after_valid got %b want 0", bus4.chk_valid); end
      n_cmp++; if (bus4.fail_cnt !== 4'd0) begin n_bad++; $display("FAIL clr_after_fail got %0d want 0", bus4.fail_cnt); end
   endtask

   task automatic test_rst_flush();
      for (int s = 0; s < 7; s++) begin
         bus2.in_valid = (s < 2);
         bus2.in_a = 16'(s + 1); bus2.in_b = 16'(s + 2); bus2.in_cin = 1'b0;
         rst = (s == 2);
         @(negedge clk);
         if (s >= 1) begin
            n_cmp++; if (bus2.chk_valid !== 1'b0) begin n_bad++; $display("FAIL flush_chk_valid[%0d] got %b want 0", s, bus2.chk_valid); end
         end
         if (s == 1) begin
            n_cmp++; if (bus2.pass_cnt !== 16'd8) begin n_bad++; $display("FAIL flush_pre_pass got %0d want 8", bus2.pass_cnt); end
         end
      end
      rst = 1'b0;
      n_cmp++; if (bus2.pass_cnt !== 16'd0) begin n_bad++; $display("FAIL flush_pass_cnt got %0d want 0", bus2.pass_cnt); end
      n_cmp++; if (bus2.fail_cnt !== 16'd0) begin n_bad++; $display("FAIL flush_fail_cnt got %0d want 0", bus2.fail_cnt); end
      n_cmp++; if (bus2.chk_ok !== 1'b0) begin n_bad++; $display("FAIL flush_chk_ok got %b want 0", bus2.chk_ok); end
      n_cmp++; if (bus2.err_flag !== 1'b0) begin n_bad++; $display("FAIL flush_err_flag got %b want 0", bus2.err_flag); end
      n_cmp++; if (bus2.ff_got !== 17'h0) begin n_bad++; $display("FAIL flush_ff_got got %h want 0", bus2.ff_got); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      va = '{16'd2, 16'd10, 16'd5, 16'd1};
      vb = '{16'd1, 16'd20, 16'd5, 16'd10};
      vc = '{1'b0, 1'b1, 1'b0, 1'b0};
      vs = '{17'd3, 17'd31, 17'd10, 17'd11};
      rst = 1'b1;
      bus0.clear = 1'b0; bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0; bus0.in_cin = 1'b0;
      bus0.dut_sum = '0; bus0.dut_cout = 1'b0;
      bus2.clear = 1'b0; bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_cin = 1'b0;
      bus4.clear = 1'b0; bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_cin = 1'b0;
      bus4.dut_sum = '0; bus4.dut_cout = 1'b0;

      test_reset();
      test_basic();
      test_mismatch();
      test_overflow();
      test_latency2();
      test_saturate();
      test_rst_flush();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
